// File: rtl/axis_tone_source.sv
// AXI-Stream test-signal source: per sample tick emits one beat per channel carrying
// a LUT sine, LFSR noise or their saturated sum, tagged with the channel index on tuser.
module axis_tone_source #(
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LUT_LEN     = 5,
  parameter logic [LUT_LEN*DATA_W-1:0] SINE_LUT =
    {24'h8643C8, 24'hB4C374, 24'h4B3C8C, 24'h79BC38, 24'h000000},
  parameter int unsigned LUT_STEP    = 2,
  parameter int unsigned CH_PHASE    = 1,
  parameter int unsigned RATE_DIV    = 2500,
  parameter int unsigned SINE_SHIFT  = 1,
  parameter int unsigned NOISE_SHIFT = 3,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_arst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [31:0]       sample_limit,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CH_W-1:0]   m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [15:0]       overrun_cnt
);

  localparam int unsigned IDX_W  = (LUT_LEN > 1) ? $clog2(LUT_LEN) : 1;
  localparam int unsigned RCNT_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [RCNT_W-1:0]   rate_q;
  logic [IDX_W-1:0]    phase_q, idx_q;
  logic [CH_W-1:0]     ch_q;
  logic [31:0]         burst_q;
  logic [31:0]         lfsr_q;
  logic [1:0]          mode_q;
  logic                stop_seen_q;
  logic [15:0]         ovr_q;

  logic tick, accept, last_ch, restart;

  // Modular add by conditional subtract; both operands are below LUT_LEN.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a, input int unsigned b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + (IDX_W+1)'(b);
    if (s >= (IDX_W+1)'(LUT_LEN)) s = s - (IDX_W+1)'(LUT_LEN);
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  assign tick    = ((state_q == StRun) || (state_q == StSend)) &&
                   (rate_q == RCNT_W'(RATE_DIV - 1));
  assign accept  = (state_q == StSend) && m_axis_tready;
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start && !stop) begin
          state_d = StRun;
          restart = 1'b1;
        end
      end
      StRun: begin
        if (stop)      state_d = StIdle;
        else if (tick) state_d = StSend;
      end
      StSend: begin
        if (accept && last_ch) begin
          if ((sample_limit != 32'd0) && (burst_q + 32'd1 == sample_limit)) state_d = StDone;
          else if (stop_seen_q || stop)                                    state_d = StIdle;
          else                                                             state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      state_q     <= StIdle;
      rate_q      <= '0;
      phase_q     <= '0;
      idx_q       <= '0;
      ch_q        <= '0;
      burst_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      mode_q      <= '0;
      stop_seen_q <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StRun) || (state_q == StSend)) begin
        rate_q <= tick ? '0 : rate_q + RCNT_W'(1);
      end
      if (restart) begin
        rate_q  <= '0;
        phase_q <= '0;
        burst_q <= '0;
      end
      if ((state_q == StRun) && (state_d == StSend)) begin
        mode_q <= mode;
        ch_q   <= '0;
        idx_q  <= phase_q;
      end
      // Stop seen mid-burst is held until the burst's last beat is accepted.
      stop_seen_q <= (state_d == StSend) && (stop_seen_q || ((state_q == StSend) && stop));
      if (accept) begin
        ch_q   <= ch_q + CH_W'(1);
        idx_q  <= idx_add(idx_q, CH_PHASE);
        lfsr_q <= lfsr_step(lfsr_q);
        if (last_ch) begin
          phase_q <= idx_add(phase_q, LUT_STEP);
          burst_q <= burst_q + 32'd1;
        end
      end
      if (tick && (state_q == StSend) && (ovr_q != 16'hFFFF)) begin
        ovr_q <= ovr_q + 16'd1;
      end
    end
  end

  logic signed [DATA_W-1:0] lut_entry, sine_term, noise_raw, noise_term, sat_sum, beat;
  logic        [DATA_W:0]   sum_ext;

  always_comb begin
    lut_entry  = SINE_LUT[idx_q*DATA_W +: DATA_W];
    sine_term  = lut_entry >>> SINE_SHIFT;
    noise_raw  = lfsr_q[DATA_W-1:0];
    noise_term = noise_raw >>> NOISE_SHIFT;
    sum_ext    = {sine_term[DATA_W-1], sine_term} + {noise_term[DATA_W-1], noise_term};
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
      sat_sum = sum_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_sum = sum_ext[DATA_W-1:0];
    end
    beat = '0;
    case (mode_q)
      2'd1:    beat = sine_term;
      2'd2:    beat = noise_term;
      2'd3:    beat = sat_sum;
      default: beat = '0;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state_q == StSend);
    m_axis_tdata  = m_axis_tvalid ? beat : '0;
    m_axis_tuser  = m_axis_tvalid ? ch_q : '0;
    m_axis_tlast  = m_axis_tvalid && last_ch;
    busy          = (state_q == StRun) || (state_q == StSend);
    done          = (state_q == StDone);
    overrun_cnt   = ovr_q;
  end

endmodule

// File: tb/tb_axis_tone_source.sv
// Bench for axis_tone_source: two instances (RATE_DIV 8 with default shifts; RATE_DIV 5
// unshifted) checked against a beat scoreboard filled when each transfer is launched.
module tb_axis_tone_source;

  typedef struct packed {
    logic [23:0] data;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_stop, a_tready, a_tvalid, a_tlast, a_busy, a_done;
  logic [1:0]  a_mode, a_tuser;
  logic [31:0] a_limit;
  logic [23:0] a_tdata;
  logic [15:0] a_ovr;
  logic        b_rst, b_start, b_stop, b_tready, b_tvalid, b_tlast, b_busy, b_done;
  logic [1:0]  b_mode, b_tuser;
  logic [31:0] b_limit;
  logic [23:0] b_tdata;
  logic [15:0] b_ovr;

  axis_tone_source #(.RATE_DIV(8)) u_dut_a (
    .s_axis_aclk(clk), .s_axis_arst(a_rst), .start(a_start), .stop(a_stop), .mode(a_mode),
    .sample_limit(a_limit), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(a_tready), .m_axis_tuser(a_tuser), .m_axis_tlast(a_tlast),
    .busy(a_busy), .done(a_done), .overrun_cnt(a_ovr)
  );

  axis_tone_source #(.RATE_DIV(5), .SINE_SHIFT(0), .NOISE_SHIFT(0)) u_dut_b (
    .s_axis_aclk(clk), .s_axis_arst(b_rst), .start(b_start), .stop(b_stop), .mode(b_mode),
    .sample_limit(b_limit), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready), .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast),
    .busy(b_busy), .done(b_done), .overrun_cnt(b_ovr)
  );

  int total = 0;
  int bad   = 0;
  int sat_hits = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t vec[8];
  int sine_tab[5] = '{0, 7978040, 4930700, -4930700, -7978040};
  logic [31:0] b_lf = 32'hACE1_2468;
  bit a_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [23:0] d, input int u, input bit l);
    beat_t b;
    b.data = d;
    b.user = 2'(u);
    b.last = l;
    return b;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  function automatic logic [23:0] model_beat(input int m, input int idx, input logic [31:0] lf,
                                             input int ss, input int ns);
    int s, n, sum;
    logic signed [23:0] n24;
    s   = sine_tab[idx] >>> ss;
    n24 = lf[23:0];
    n   = n24;
    n   = n >>> ns;
    sum = s + n;
    if (sum > 8388607)  sum = 8388607;
    if (sum < -8388608) sum = -8388608;
    case (m)
      0:       return 24'd0;
      1:       return 24'(s);
      2:       return 24'(n);
      default: return 24'(sum);
    endcase
  endfunction

  // Instance B bursts from phase 0; noise model advances once per expected beat.
  task automatic push_b(input int m, input int nbursts);
    for (int bb = 0; bb < nbursts; bb++) begin
      for (int c = 0; c < 4; c++) begin
        qb.push_back(mk(model_beat(m, ((bb * 2) % 5 + c) % 5, b_lf, 0, 0), c, c == 3));
        b_lf = lfsr_next(b_lf);
      end
    end
  endtask

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) qa.push_back(vec[i]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_a_done(input int budget, input string name);
    int n = 0;
    while (!a_done && n < budget) begin step(1); n++; end
    check(name, 64'(a_done), 64'd1);
  endtask

  task automatic wait_b_done(input int budget, input string name);
    int n = 0;
    while (!b_done && n < budget) begin step(1); n++; end
    check(name, 64'(b_done), 64'd1);
  endtask

  always @(posedge clk) begin
    if (a_rand) begin
      #1;
      a_tready = 1'($urandom_range(0, 1));
    end
  end

  beat_t a_hold, b_hold, e;
  bit    a_hold_v = 1'b0, b_hold_v = 1'b0;

  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_hold_v) check("a_stall_stable", 64'({a_tvalid, a_tdata, a_tuser, a_tlast}),
                          64'({1'b1, a_hold}));
      a_hold_v = a_tvalid && !a_tready;
      a_hold   = {a_tdata, a_tuser, a_tlast};
      if (a_tvalid && a_tready) begin
        if (qa.size() == 0) check("a_extra_beat", 64'({a_tdata, a_tuser, a_tlast}), 64'd0 - 1);
        else begin
          e = qa.pop_front();
          check("a_beat", 64'({a_tdata, a_tuser, a_tlast}), 64'(e));
        end
      end
    end
    if (!b_rst) begin
      if (b_hold_v) check("b_stall_stable", 64'({b_tvalid, b_tdata, b_tuser, b_tlast}),
                          64'({1'b1, b_hold}));
      b_hold_v = b_tvalid && !b_tready;
      b_hold   = {b_tdata, b_tuser, b_tlast};
      if (b_tvalid && b_tready) begin
        if (b_tdata == 24'h7FFFFF || b_tdata == 24'h800000) sat_hits++;
        if (qb.size() == 0) check("b_extra_beat", 64'({b_tdata, b_tuser, b_tlast}), 64'd0 - 1);
        else begin
          e = qb.pop_front();
          check("b_beat", 64'({b_tdata, b_tuser, b_tlast}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vdat[8] = '{0, 3989020, 2465350, -2465350, 2465350, -2465350, -3989020, 0};
    int n;
    for (int i = 0; i < 8; i++) vec[i] = mk(24'(vdat[i]), i % 4, (i % 4) == 3);

    a_rst = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_mode = 2'd0; a_limit = 32'd0; a_tready = 1'b1;
    b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_mode = 2'd0; b_limit = 32'd0; b_tready = 1'b1;
    a_start = 1'b1;  // reset must win over start
    step(5);
    check("a_reset_outputs",
          64'({a_tdata, a_tvalid, a_tuser, a_tlast, a_busy, a_done, a_ovr}), 64'd0);
    a_start = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("a_idle_quiet", 64'({a_tvalid, a_busy, a_ovr}), 64'd0);
    end

    // Two sine bursts, always ready.
    push_a(8);
    a_mode = 2'd1; a_limit = 32'd2;
    a_start = 1'b1; step(1); a_start = 1'b0;
    wait_a_done(200, "a_done_limit2");
    check("a_done_not_busy", 64'({a_done, a_busy}), 64'b10);
    check("a_queue_drained", 64'(qa.size()), 64'd0);

    // Same bursts with random backpressure; restart from DONE begins at phase 0.
    push_a(8);
    a_rand = 1'b1;
    a_start = 1'b1; step(1); a_start = 1'b0;
    wait_a_done(600, "a_done_random_ready");
    a_rand = 1'b0; step(1); a_tready = 1'b1;
    check("a_queue_drained_rand", 64'(qa.size()), 64'd0);

    // Instance B: 20-cycle stall across four ticks.
    push_b(1, 1);
    b_mode = 2'd1; b_limit = 32'd1; b_tready = 1'b0;
    b_start = 1'b1; step(1); b_start = 1'b0;
    n = 0;
    while (!b_tvalid && n < 50) begin @(negedge clk); n++; end
    check("b_first_valid", 64'(b_tvalid), 64'd1);
    repeat (20) @(posedge clk);
    #1 b_tready = 1'b1;
    wait_b_done(50, "b_done_overrun");
    check("b_overrun_cnt", 64'(b_ovr), 64'd4);
    check("b_queue_drained_ovr", 64'(qb.size()), 64'd0);

    // Unshifted sine+noise must saturate, never wrap.
    push_b(3, 10);
    b_mode = 2'd3; b_limit = 32'd10;
    b_start = 1'b1; step(1); b_start = 1'b0;
    wait_b_done(400, "b_done_sat");
    check("b_queue_drained_sat", 64'(qb.size()), 64'd0);
    check("b_sat_hits_seen", 64'(sat_hits > 0), 64'd1);

    // Continuous mode, stop during channel 2: burst completes, then idle.
    push_a(4);
    a_limit = 32'd0;
    a_start = 1'b1; step(1); a_start = 1'b0;
    n = 0;
    while (!(a_tvalid && a_tuser == 2'd1) && n < 100) begin @(negedge clk); n++; end
    check("a_reach_ch1", 64'({a_tvalid, a_tuser}), 64'b101);
    @(posedge clk); #1 a_stop = 1'b1;
    step(1); a_stop = 1'b0;
    n = 0;
    while (a_busy && n < 50) begin step(1); n++; end
    check("a_stop_to_idle", 64'({a_busy, a_done}), 64'b00);
    check("a_queue_drained_stop", 64'(qa.size()), 64'd0);
    step(30);

    // Restart after stop begins at phase 0.
    push_a(4);
    a_limit = 32'd1;
    a_start = 1'b1; step(1); a_start = 1'b0;
    wait_a_done(100, "a_done_restart");
    check("a_queue_drained_restart", 64'(qa.size()), 64'd0);

    // Start with stop in the same cycle: stop wins.
    a_start = 1'b1; a_stop = 1'b1; step(1); a_start = 1'b0; a_stop = 1'b0;
    step(2);
    check("a_start_stop_same", 64'({a_busy, a_done}), 64'b01);

    // Stop while waiting for a tick: idle on the next cycle.
    a_limit = 32'd0;
    a_start = 1'b1; step(1); a_start = 1'b0;
    check("a_run_busy", 64'(a_busy), 64'd1);
    a_stop = 1'b1; step(1); a_stop = 1'b0;
    check("a_stop_in_run", 64'({a_busy, a_done}), 64'b00);
    step(20);

    check("a_queue_final", 64'(qa.size()), 64'd0);
    check("b_queue_final", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
